lcd_string_writer: RTL and testbench
====================================

Name: lcd_string_writer

Overview:
Sequencer between the command layer and the LCD transaction layer. It takes a 16-character ASCII line and a start pulse, issues a cursor-home request, then streams the characters left to right through the transaction layer's write handshake. Reports busy while active and a one-cycle done pulse on completion, so the command FSM needs one start/done exchange per refresh instead of per-byte bookkeeping.

Parameters:
NUM_CHARS, 16, characters per line; string_in width is NUM_CHARS*8
CNT_W, 5, width of the character counter; must hold NUM_CHARS

Ports:
clk  input  1  divided system clock; all logic on posedge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to write string_in; sampled only in IDLE
string_in  input  NUM_CHARS*8  line to display, MSB byte = leftmost character
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when the last character is acknowledged
do_return_cursor_home  output  1  level request to transaction layer
return_cursor_home_done  input  1  level acknowledge from transaction layer
do_write_data  output  1  level request to transaction layer
data_to_write  output  8  character for the current write request
send_data_done  input  1  level acknowledge from transaction layer

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, do_return_cursor_home=0, do_write_data=0, data_to_write=8'h00, counter=0, line latch=0.
- States: IDLE, HOME_REQ, HOME_REL, LOAD, WR_REQ, WR_REL, FINISH.
- IDLE: start=1 -> latch string_in into internal line register, counter=NUM_CHARS, busy=1 next cycle, go HOME_REQ. start=0 -> stay.
- HOME_REQ: do_return_cursor_home=1; stay until return_cursor_home_done=1, then drop request next cycle, go HOME_REL.
- HOME_REL: request low; wait for return_cursor_home_done=0, then LOAD. Prevents one long ack being counted twice.
- LOAD: data_to_write = latched byte at index counter (counter=NUM_CHARS -> bits [NUM_CHARS*8-1 -: 8], counter=1 -> bits [7:0]); go WR_REQ. data_to_write is stable at least one cycle before do_write_data rises and does not change until the ack is released.
- WR_REQ: do_write_data=1; hold until send_data_done=1; then drop request, counter=counter-1, go WR_REL.
- WR_REL: wait for send_data_done=0; then counter==0 -> FINISH, else LOAD.
- FINISH: done=1 for exactly one cycle, busy=0 in the same cycle, go IDLE.
- start while busy: ignored, no restart, no latch update. Changes to string_in after acceptance do not affect the line being written.
- Ack already high on entry to a *_REQ state: the request still asserts for at least one cycle, then the ack is taken.
- Exactly NUM_CHARS write requests per start. Counter never wraps; underflow is unreachable.
- Only one of do_return_cursor_home / do_write_data is high in any cycle.
- Minimum latency with single-cycle acks: 1 (accept) + 2 (home) + NUM_CHARS*3 (load/req/rel) + 1 (finish) cycles, i.e. 52 for NUM_CHARS=16.
- Reset mid-operation: all requests drop immediately (async). No done pulse. The next start begins a full sequence from cursor home.

Test Plan:
- Basic line: string_in="CP=15 I=20 TP=20", single-cycle ack model -> one home request, then 16 writes with bytes 0x43,0x50,0x3D,0x31,0x35,0x20,...,0x32,0x30 in order; done pulses once in cycle 52 after start; busy high cycles 1-51.
- Slow acks: send_data_done asserted 5 cycles after each request and held 3 cycles -> still exactly 16 writes, no duplicate byte, data_to_write stable for each whole request.
- Start while busy: second start with a different string at write #4 -> ignored; the original 16 bytes complete, one done pulse, no second home request.
- Reset mid-stream: assert reset during write #7 -> same cycle do_write_data=0, busy=0, data_to_write=0x00. Release, then start "ABCDEFGHIJKLMNOP" -> home request, then 0x41..0x50.
- Stuck-high ack: send_data_done held high across LOAD -> block waits in WR_REL and does not advance until ack falls; counter unchanged.
- Back-to-back: start pulsed in the cycle after done -> accepted, second full sequence begins with a home request.

Source files
------------

// File: rtl/lcd_string_writer.sv
// lcd_string_writer: streams a latched line of ASCII characters to the LCD
// transaction layer. It issues one cursor-home request, then one write request
// per character, and ends with a single-cycle done pulse.
// Every request/acknowledge pair is fully closed: the request drops and the
// block then waits for the acknowledge to fall before it moves on.
module lcd_string_writer #(
  parameter int NUM_CHARS = 16,
  parameter int CNT_W     = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NUM_CHARS*8-1:0] string_in,
  output logic                   busy,
  output logic                   done,
  output logic                   do_return_cursor_home,
  input  logic                   return_cursor_home_done,
  output logic                   do_write_data,
  output logic [7:0]             data_to_write,
  input  logic                   send_data_done
);

  typedef enum logic [2:0] {
    IDLE, HOME_REQ, HOME_REL, LOAD, WR_REQ, WR_REL, FINISH
  } state_t;

  state_t                 state, nxt;
  logic [NUM_CHARS*8-1:0] line_q;
  logic [CNT_W-1:0]       cnt;
  logic                   accept, load_byte, cnt_dec;
  logic [7:0]             sel_byte;

  // Requests are decoded from state so they drop the moment reset hits.
  assign do_return_cursor_home = (state == HOME_REQ);
  assign do_write_data         = (state == WR_REQ);

  // Byte picked by the counter: cnt==NUM_CHARS is the leftmost (MSB) byte,
  // cnt==1 is the rightmost.
  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < NUM_CHARS; i++)
      if (cnt == CNT_W'(i + 1)) sel_byte = line_q[i*8 +: 8];
  end

  // Next-state logic. The byte is loaded on entry to LOAD, so it is stable
  // for the whole LOAD cycle before the write request rises.
  always_comb begin
    nxt       = state;
    accept    = 1'b0;
    load_byte = 1'b0;
    cnt_dec   = 1'b0;
    case (state)
      IDLE:     if (start) begin accept = 1'b1; nxt = HOME_REQ; end
      HOME_REQ: if (return_cursor_home_done) nxt = HOME_REL;
      HOME_REL: if (!return_cursor_home_done) begin nxt = LOAD; load_byte = 1'b1; end
      LOAD:     nxt = WR_REQ;
      WR_REQ:   if (send_data_done) begin nxt = WR_REL; cnt_dec = 1'b1; end
      WR_REL: begin
        if (!send_data_done) begin
          if (cnt == '0) nxt = FINISH;
          else begin nxt = LOAD; load_byte = 1'b1; end
        end
      end
      FINISH:   nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  // State register, line latch, character counter and handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      line_q        <= '0;
      cnt           <= '0;
      data_to_write <= 8'h00;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state <= nxt;
      done  <= (state == FINISH);
      if (accept) begin
        line_q <= string_in;
        cnt    <= CNT_W'(NUM_CHARS);
        busy   <= 1'b1;
      end else if (state == FINISH) begin
        busy <= 1'b0;
      end
      if (cnt_dec)   cnt           <= cnt - 1'b1;
      if (load_byte) data_to_write <= sel_byte;
    end
  end

endmodule

// File: tb/tb_lcd_string_writer.sv
// tb_lcd_string_writer: directed checks of the LCD line writer with a
// selectable acknowledge model (immediate, slow, manually held).
module tb_lcd_string_writer;
  localparam int N = 16;

  logic           clk = 1'b0;
  logic           reset, start;
  logic [N*8-1:0] string_in;
  logic           busy, done, do_return_cursor_home, return_cursor_home_done;
  logic           do_write_data, send_data_done;
  logic [7:0]     data_to_write;

  int   n_chk = 0, n_fail = 0;
  int   amode = 0;          // 0 immediate ack, 1 slow ack, 2 manual write ack
  logic ack_s = 1'b0;
  logic man_wr = 1'b0;
  int   s_dly = 0, s_hold = 0;

  logic [N*8-1:0] s1 = "CP=15 I=20 TP=20";
  logic [N*8-1:0] s2 = "xyzw0123456789!?";
  logic [N*8-1:0] s3 = "ABCDEFGHIJKLMNOP";

  logic [7:0] wr_log[$];
  int         home_cnt = 0, done_cnt = 0;
  logic       prev_w = 1'b0, prev_h = 1'b0;
  logic [7:0] prev_d = 8'h00, cur_b = 8'h00;

  lcd_string_writer #(.NUM_CHARS(N), .CNT_W(5)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .start                   (start),
    .string_in               (string_in),
    .busy                    (busy),
    .done                    (done),
    .do_return_cursor_home   (do_return_cursor_home),
    .return_cursor_home_done (return_cursor_home_done),
    .do_write_data           (do_write_data),
    .data_to_write           (data_to_write),
    .send_data_done          (send_data_done)
  );

  always #5 clk = ~clk;

  assign return_cursor_home_done = (amode == 1) ? ack_s : do_return_cursor_home;
  assign send_data_done = (amode == 0) ? do_write_data :
                          (amode == 1) ? ack_s : man_wr;

  // Slow responder: ack rises 5 cycles after a request and is held 3 cycles.
  always @(posedge clk) begin
    if (amode != 1) begin
      ack_s <= 1'b0; s_dly <= 0; s_hold <= 0;
    end else if (ack_s) begin
      if (s_hold == 2) begin ack_s <= 1'b0; s_hold <= 0; end
      else s_hold <= s_hold + 1;
    end else if (do_write_data || do_return_cursor_home) begin
      if (s_dly == 4) begin ack_s <= 1'b1; s_dly <= 0; end
      else s_dly <= s_dly + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus monitor: logs each write, counts home requests and done pulses.
  always @(negedge clk) begin
    chk("excl_req", {31'b0, do_write_data & do_return_cursor_home}, 32'd0);
    if (do_write_data && !prev_w) begin
      wr_log.push_back(data_to_write);
      cur_b = data_to_write;
      chk("data_pre_stable", {24'b0, data_to_write}, {24'b0, prev_d});
    end else if (do_write_data) begin
      chk("data_req_stable", {24'b0, data_to_write}, {24'b0, cur_b});
    end
    if (do_return_cursor_home && !prev_h) home_cnt++;
    if (done) done_cnt++;
    prev_w = do_write_data;
    prev_h = do_return_cursor_home;
    prev_d = data_to_write;
  end

  task automatic clear_log();
    wr_log.delete();
    home_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic pulse_start(input logic [N*8-1:0] s);
    @(negedge clk); start = 1'b1; string_in = s;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_log(input int n, input int max);
    int c = 0;
    while (wr_log.size() < n && c < max) begin @(negedge clk); #1; c++; end
    chk("log_reached", (wr_log.size() >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_done_cnt(input int n, input int max);
    int c = 0;
    while (done_cnt < n && c < max) begin @(negedge clk); #1; c++; end
    chk("done_reached", (done_cnt >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic chk_line(input logic [N*8-1:0] s, input int base);
    logic [7:0] e;
    for (int i = 0; i < N; i++) begin
      e = s[N*8-1-8*i -: 8];
      chk($sformatf("byte%0d", base + i), {24'b0, wr_log[base + i]}, {24'b0, e});
    end
  endtask

  initial begin
    int done_k, busy_n;
    reset = 1'b1; start = 1'b0; string_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_home", do_return_cursor_home, 0);
    chk("rst_wr", do_write_data, 0);
    chk("rst_data", data_to_write, 0);
    reset = 1'b0;

    // Basic line with immediate acks: latency and byte order.
    clear_log();
    @(negedge clk); start = 1'b1; string_in = s1;
    done_k = 0; busy_n = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) begin start = 1'b0; chk("busy_after_accept", busy, 1); end
      if (busy) busy_n++;
      if (done && done_k == 0) done_k = k;
    end
    chk("done_cycle", done_k, 52);
    chk("busy_cycles", busy_n, 51);
    chk("basic_writes", wr_log.size(), 16);
    chk("basic_home", home_cnt, 1);
    chk("basic_done", done_cnt, 1);
    chk_line(s1, 0);

    // Slow acknowledges.
    clear_log(); amode = 1;
    pulse_start(s3);
    wait_done_cnt(1, 400);
    chk("slow_writes", wr_log.size(), 16);
    chk("slow_home", home_cnt, 1);
    chk_line(s3, 0);
    amode = 0;

    // Start while busy is ignored.
    clear_log();
    pulse_start(s1);
    wait_log(4, 100);
    pulse_start(s2);
    wait_done_cnt(1, 200);
    repeat (5) @(negedge clk); #1;
    chk("busy_start_writes", wr_log.size(), 16);
    chk("busy_start_home", home_cnt, 1);
    chk("busy_start_done", done_cnt, 1);
    chk_line(s1, 0);

    // Reset during write #7, then a fresh line.
    clear_log();
    pulse_start(s1);
    wait_log(7, 100);
    chk("w7_active", do_write_data, 1);
    reset = 1'b1; #1;
    chk("mid_rst_wr", do_write_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_data", data_to_write, 0);
    @(negedge clk); @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk); #1;
    chk("mid_rst_no_done", done_cnt, 0);
    clear_log();
    pulse_start(s3);
    wait_done_cnt(1, 200);
    chk("after_rst_home", home_cnt, 1);
    chk("after_rst_writes", wr_log.size(), 16);
    chk_line(s3, 0);

    // Write ack stuck high: block must hold in the release state.
    clear_log(); amode = 2; man_wr = 1'b0;
    pulse_start(s1);
    wait_log(1, 50);
    man_wr = 1'b1;
    repeat (10) @(negedge clk); #1;
    chk("stuck_writes", wr_log.size(), 1);
    chk("stuck_wr_low", do_write_data, 0);
    chk("stuck_busy", busy, 1);
    man_wr = 1'b0;
    repeat (3) @(negedge clk); #1;
    chk("unstuck_wr", do_write_data, 1);
    chk("unstuck_writes", wr_log.size(), 2);
    chk("unstuck_byte", data_to_write, 8'h50);
    amode = 0;
    wait_done_cnt(1, 200);
    chk("stuck_total", wr_log.size(), 16);
    chk_line(s1, 0);

    // Back-to-back: start in the cycle after done.
    clear_log();
    pulse_start(s1);
    wait_done_cnt(1, 100);
    pulse_start(s2);
    wait_done_cnt(2, 100);
    chk("b2b_home", home_cnt, 2);
    chk("b2b_writes", wr_log.size(), 32);
    chk_line(s1, 0);
    chk_line(s2, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
